// File: rtl/notch_avalon_pkg.sv
// Shared constants for the notch filter's Avalon-MM SDRAM path: error word,
// stall-injector LFSR definition, debug selects and the master's word stride.
package notch_avalon_pkg;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;
    localparam int          SDRAM_WORD_SKIP  = 2;

    // Right-shifting Fibonacci LFSR; mask selects taps 16,14,13,11 (bits 0,2,3,5).
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [15:0] LFSR_FB_MASK = 16'h002D;

    typedef enum logic [1:0] {
        DBG_RD_CNT  = 2'd0,
        DBG_WR_CNT  = 2'd1,
        DBG_PENDING = 2'd2,
        DBG_ERR     = 2'd3
    } dbg_sel_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_FB_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/sdram_sample_responder_delay.sv
// Fixed-latency response pipe: {valid, data} shifts one stage per clock and
// the last stage drives the Avalon response.
module resp_delay_line #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_p  [DEPTH];
    logic [DATA_W-1:0] data_p [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= in_valid;
            data_p[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_p[i]  <= vld_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign out_valid = vld_p[DEPTH-1];
    assign out_data  = data_p[DEPTH-1];

endmodule

// File: rtl/sdram_sample_responder.sv
// Avalon-MM pipelined slave: word RAM with waitrequest backpressure, fixed
// read latency, seeded stall injection and a registered debug port.
module sdram_sample_responder
    import notch_avalon_pkg::*;
#(
    parameter int          ADDR_W         = 24,
    parameter int          DEPTH_LOG2     = 10,
    parameter int          WORD_SKIP_LOG2 = SDRAM_WORD_SKIP,
    parameter int          READ_LATENCY   = 3,
    parameter int          MAX_PENDING    = 2,
    parameter logic [31:0] ERR_WORD       = ERR_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic              waitrequest,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    input  logic              stall_en,
    input  logic [1:0]        dbg_sel,
    output logic [31:0]       dbg_data,
    output logic              err
);

    localparam int IDX_W  = ADDR_W - WORD_SKIP_LOG2;
    localparam int PEND_W = 4;

    logic [31:0]       mem [0:(1<<DEPTH_LOG2)-1];
    logic [15:0]       lfsr;
    logic [PEND_W-1:0] pending;
    logic [31:0]       rd_cnt;
    logic [31:0]       wr_cnt;
    logic              err_q;

    logic [IDX_W-1:0]  word_idx;
    logic              unused_addr_lsb;
    logic              in_range;
    logic              collide;
    logic              full;
    logic              rd_acc;
    logic              wr_acc;
    logic              err_set;
    logic [31:0]       rd_word;
    logic              dl_vld;
    logic [31:0]       dl_data;

    assign word_idx        = address[ADDR_W-1:WORD_SKIP_LOG2];
    assign unused_addr_lsb = ^address[WORD_SKIP_LOG2-1:0];
    assign in_range        = (word_idx >> DEPTH_LOG2) == '0;

    // A retiring response frees its slot in the same cycle, so a full pipe
    // still accepts a read when readdatavalid is high.
    assign collide     = read & write;
    assign full        = (pending == PEND_W'(MAX_PENDING)) & ~dl_vld;
    assign waitrequest = reset | (stall_en & lfsr[0]) | collide | (read & full);
    assign rd_acc      = read & ~waitrequest;
    assign wr_acc      = write & ~waitrequest;
    assign err_set     = collide | ((rd_acc | wr_acc) & ~in_range);

    // Reads never share an accepted cycle with a write, so the asynchronous
    // read always sees the RAM as it was before this edge.
    assign rd_word = in_range ? mem[word_idx[DEPTH_LOG2-1:0]] : ERR_WORD;

    always_ff @(posedge clk) begin
        if (wr_acc && in_range)
            mem[word_idx[DEPTH_LOG2-1:0]] <= writedata;
    end

    resp_delay_line #(
        .DEPTH  (READ_LATENCY),
        .DATA_W (32)
    ) u_delay (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (rd_acc),
        .in_data   (rd_acc ? rd_word : 32'd0),
        .out_valid (dl_vld),
        .out_data  (dl_data)
    );

    assign readdatavalid = dl_vld;
    assign readdata      = dl_data;
    assign err           = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= LFSR_SEED;
            pending  <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            err_q    <= 1'b0;
            dbg_data <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);

            if (rd_acc && !dl_vld)
                pending <= pending + PEND_W'(1);
            else if (!rd_acc && dl_vld)
                pending <= pending - PEND_W'(1);

            if (rd_acc)
                rd_cnt <= rd_cnt + 32'd1;
            if (wr_acc)
                wr_cnt <= wr_cnt + 32'd1;
            if (err_set)
                err_q <= 1'b1;

            case (dbg_sel_e'(dbg_sel))
                DBG_RD_CNT:  dbg_data <= rd_cnt;
                DBG_WR_CNT:  dbg_data <= wr_cnt;
                DBG_PENDING: dbg_data <= {{(32-PEND_W){1'b0}}, pending};
                DBG_ERR:     dbg_data <= {31'b0, err_q};
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_sample_responder.sv
// Bench for sdram_sample_responder: cycle driver with a queue-based response
// scoreboard and RAM model, plus directed and randomized scenario tasks.
module tb_sdram_sample_responder;

    localparam int ADDR_W = 24;
    localparam int WORDS  = 1024;
    localparam int RL     = 3;
    localparam int MP     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              stall_en;
    logic [1:0]        dbg_sel;
    logic [31:0]       dbg_data;
    logic              err;

    always #5 clk = ~clk;

    sdram_sample_responder dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .stall_en      (stall_en),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data),
        .err           (err)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    resp_t       rq[$];
    logic [31:0] got_q[$];
    int          got_cyc_q[$];
    logic [31:0] mem_m [WORDS];
    logic [15:0] m_lfsr = 16'hACE1;
    logic [31:0] m_rd   = 0;
    logic [31:0] m_wr   = 0;
    logic        m_err  = 1'b0;
    logic        last_wait;

    // One bus cycle: drive, compare live outputs with the model, then advance the model.
    task automatic cycle(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic rs);
        logic  retire;
        logic  exp_wait;
        int    idx;
        resp_t e;
        read = r; write = w; address = a; writedata = d; reset = rs;
        #1;
        retire   = (rq.size() > 0) && (rq[0].due == cyc);
        exp_wait = rs || (stall_en && m_lfsr[0]) || (r && w) ||
                   (r && rq.size() == MP && !retire);
        last_wait = waitrequest;
        checks++;
        if (waitrequest !== exp_wait) begin
            errors++;
            $display("FAIL waitrequest cyc=%0d got=%b exp=%b", cyc, waitrequest, exp_wait);
        end
        checks++;
        if (readdatavalid !== retire) begin
            errors++;
            $display("FAIL readdatavalid cyc=%0d got=%b exp=%b", cyc, readdatavalid, retire);
        end
        if (retire) begin
            checks++;
            if (readdata !== rq[0].data) begin
                errors++;
                $display("FAIL readdata cyc=%0d got=%h exp=%h", cyc, readdata, rq[0].data);
            end
        end
        checks++;
        if (err !== m_err) begin
            errors++;
            $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err, m_err);
        end
        if (readdatavalid === 1'b1) begin
            got_q.push_back(readdata);
            got_cyc_q.push_back(cyc);
        end
        @(posedge clk);
        if (rs) begin
            rq.delete();
            m_lfsr = 16'hACE1;
            m_rd   = 0;
            m_wr   = 0;
            m_err  = 1'b0;
        end else begin
            idx = int'(a >> 2);
            if (retire) void'(rq.pop_front());
            if (r && w) m_err = 1'b1;
            if (r && !exp_wait) begin
                m_rd++;
                e.due = cyc + RL;
                if (idx < WORDS) e.data = mem_m[idx];
                else begin
                    e.data = 32'hDEADBEEF;
                    m_err  = 1'b1;
                end
                rq.push_back(e);
            end
            if (w && !exp_wait) begin
                m_wr++;
                if (idx < WORDS) mem_m[idx] = d;
                else m_err = 1'b1;
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 32'd0, 1'b0);
    endtask

    task automatic pulse_reset();
        cycle(1'b0, 1'b0, '0, 32'd0, 1'b1);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, '0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, '0, 32'd0, 1'b1);
        checks++;
        if (waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait got=%b exp=1", waitrequest); end
        checks++;
        if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv got=%b exp=0", readdatavalid); end
        checks++;
        if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", readdata); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++;
        if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_dbg got=%h exp=0", dbg_data); end
    endtask

    task automatic preload_ram();
        for (int i = 0; i < WORDS; i++)
            cycle(1'b0, 1'b1, ADDR_W'(i * 4), $urandom, 1'b0);
    endtask

    task automatic test_write_read();
        int acc_cyc;
        pulse_reset();
        got_q.delete();
        got_cyc_q.delete();
        cycle(1'b0, 1'b1, 24'h10, 32'h11223344, 1'b0);
        idle(1);
        acc_cyc = cyc;
        cycle(1'b1, 1'b0, 24'h10, 32'd0, 1'b0);
        idle(5);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL wr_rd_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'h11223344) begin errors++; $display("FAIL wr_rd_data got=%h exp=11223344", got_q[0]); end
            checks++;
            if (got_cyc_q[0] - acc_cyc != 3) begin errors++; $display("FAIL wr_rd_latency got=%0d exp=3", got_cyc_q[0] - acc_cyc); end
        end
        dbg_sel = 2'd0;
        idle(1);
        checks++;
        if (dbg_data !== 32'd1) begin errors++; $display("FAIL dbg_reads got=%0d exp=1", dbg_data); end
        dbg_sel = 2'd1;
        idle(1);
        checks++;
        if (dbg_data !== 32'd1) begin errors++; $display("FAIL dbg_writes got=%0d exp=1", dbg_data); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  pat;
        logic [31:0] peak;
        int          k;
        int          n;
        idle(6);
        got_q.delete();
        dbg_sel = 2'd2;
        pat  = '0;
        peak = 0;
        k    = 0;
        n    = 0;
        while (k < 6 && n < 40) begin
            cycle(1'b1, 1'b0, ADDR_W'(k * 4), 32'd0, 1'b0);
            if (n < 6) pat[n] = last_wait;
            if (!last_wait) k++;
            if (dbg_data > peak) peak = dbg_data;
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (dbg_data > peak) peak = dbg_data;
        end
        checks++;
        if (k != 6) begin errors++; $display("FAIL b2b_accepts got=%0d exp=6", k); end
        checks++;
        if (pat !== 6'b100100) begin errors++; $display("FAIL b2b_wait_pattern got=%b exp=100100", pat); end
        checks++;
        if (peak !== 32'd2) begin errors++; $display("FAIL b2b_peak_pending got=%0d exp=2", peak); end
        checks++;
        if (got_q.size() != 6) begin
            errors++; $display("FAIL b2b_responses got=%0d exp=6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_q[i] !== mem_m[i]) begin
                    errors++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, got_q[i], mem_m[i]);
                end
            end
        end
    endtask

    task automatic test_rw_order();
        cycle(1'b0, 1'b1, 24'h20, 32'hA5A50001, 1'b0);
        idle(4);
        got_q.delete();
        cycle(1'b1, 1'b0, 24'h20, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 24'h20, 32'd5, 1'b0);
        cycle(1'b1, 1'b0, 24'h20, 32'd0, 1'b0);
        idle(5);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL rw_count got=%0d exp=2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'hA5A50001) begin errors++; $display("FAIL rw_old got=%h exp=a5a50001", got_q[0]); end
            checks++;
            if (got_q[1] !== 32'd5) begin errors++; $display("FAIL rw_new got=%h exp=5", got_q[1]); end
        end
    endtask

    task automatic test_errors();
        pulse_reset();
        cycle(1'b1, 1'b1, 24'h4, 32'h77, 1'b0);
        checks++;
        if (last_wait !== 1'b1) begin errors++; $display("FAIL collide_wait got=%b exp=1", last_wait); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL collide_err got=%b exp=1", err); end
        dbg_sel = 2'd0;
        idle(1);
        checks++;
        if (dbg_data !== 32'd0) begin errors++; $display("FAIL collide_reads got=%0d exp=0", dbg_data); end
        dbg_sel = 2'd1;
        idle(1);
        checks++;
        if (dbg_data !== 32'd0) begin errors++; $display("FAIL collide_writes got=%0d exp=0", dbg_data); end
        got_q.delete();
        cycle(1'b1, 1'b0, 24'h1000, 32'd0, 1'b0);
        cycle(1'b0, 1'b1, 24'h1000, 32'h12345678, 1'b0);
        cycle(1'b1, 1'b0, 24'h0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 24'hFFC, 32'd0, 1'b0);
        idle(6);
        checks++;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL oor_count got=%0d exp=3", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_data got=%h exp=deadbeef", got_q[0]); end
            checks++;
            if (got_q[1] !== mem_m[0]) begin errors++; $display("FAIL oor_write_dropped got=%h exp=%h", got_q[1], mem_m[0]); end
            checks++;
            if (got_q[2] !== mem_m[WORDS-1]) begin errors++; $display("FAIL last_word got=%h exp=%h", got_q[2], mem_m[WORDS-1]); end
        end
        dbg_sel = 2'd3;
        idle(1);
        checks++;
        if (dbg_data !== 32'd1) begin errors++; $display("FAIL err_sticky_dbg got=%0d exp=1", dbg_data); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        idle(2);
        cycle(1'b1, 1'b0, 24'h40, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 24'h44, 32'd0, 1'b0);
        pulse_reset();
        got_q.delete();
        dbg_sel = 2'd2;
        idle(6);
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL midreset_responses got=%0d exp=0", got_q.size()); end
        checks++;
        if (dbg_data !== 32'd0) begin errors++; $display("FAIL midreset_pending got=%0d exp=0", dbg_data); end
        cycle(1'b1, 1'b0, 24'h44, 32'd0, 1'b0);
        idle(5);
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL midreset_ram_count got=%0d exp=1", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== mem_m[17]) begin errors++; $display("FAIL midreset_ram got=%h exp=%h", got_q[0], mem_m[17]); end
        end
    endtask

    task automatic test_random_stall();
        int          wait_cnt;
        int          op;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
        pulse_reset();
        got_q.delete();
        stall_en = 1'b1;
        wait_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            op = $urandom_range(0, 2);
            cycle(op == 1, op == 2, ADDR_W'($urandom_range(0, 31) * 4), $urandom, 1'b0);
            if (last_wait) wait_cnt++;
        end
        stall_en = 1'b0;
        idle(8);
        exp_rd = m_rd;
        exp_wr = m_wr;
        checks++;
        if (wait_cnt < 400 || wait_cnt > 600) begin
            errors++; $display("FAIL stall_ratio got=%0d exp=400..600", wait_cnt);
        end
        checks++;
        if (got_q.size() != int'(exp_rd)) begin
            errors++; $display("FAIL stall_responses got=%0d exp=%0d", got_q.size(), exp_rd);
        end
        dbg_sel = 2'd0;
        idle(1);
        checks++;
        if (dbg_data !== exp_rd) begin errors++; $display("FAIL stall_reads got=%0d exp=%0d", dbg_data, exp_rd); end
        dbg_sel = 2'd1;
        idle(1);
        checks++;
        if (dbg_data !== exp_wr) begin errors++; $display("FAIL stall_writes got=%0d exp=%0d", dbg_data, exp_wr); end
    endtask

    initial begin
        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = '0;
        writedata = '0;
        stall_en  = 1'b0;
        dbg_sel   = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        test_reset();
        preload_ram();
        test_write_read();
        test_back_to_back();
        test_rw_order();
        test_errors();
        test_reset_mid();
        test_random_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_sample_responder.md
# sdram_sample_responder

Avalon-MM pipelined slave that answers the notch filter's SDRAM master port: word RAM behind `read`/`write`, `waitrequest` backpressure and fixed-latency `readdatavalid` responses. Used as the on-chip sample store in the filter subsystem and as the protocol-accurate partner for the master's read/request FIFO pipeline. A seeded stall injector exercises the master's wait handling. Status counters sit on a small read-only debug port.

## Interface
- `ADDR_W`, 24: byte address width.
- `DEPTH_LOG2`, 10: RAM holds 2^DEPTH_LOG2 32-bit words.
- `WORD_SKIP_LOG2`, 2: word index = `address >> WORD_SKIP_LOG2`.
- `READ_LATENCY`, 3: cycles from read acceptance to `readdatavalid`; legal range 1..8.
- `MAX_PENDING`, 2: outstanding-read cap; legal range 1..READ_LATENCY.
- `ERR_WORD`, 32'hDEADBEEF: data returned for out-of-range reads.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `address` in ADDR_W: byte address.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in 32: write data.
- `waitrequest` out 1: request not accepted this cycle.
- `readdata` out 32: response data.
- `readdatavalid` out 1: `readdata` valid this cycle.
- `stall_en` in 1: enable pseudo-random wait injection.
- `dbg_sel` in 2: selects `dbg_data` (0 reads accepted, 1 writes accepted, 2 pending, 3 {31'b0, err}).
- `dbg_data` out 32: debug value, registered.
- `err` out 1: sticky protocol/range error.

## Operation
- Acceptance: read or write is accepted in a cycle where it is high and `waitrequest` is low.
- `waitrequest` is combinational from registered state and `read`/`write`. It is 1 when any of the following holds:
  - `reset` is high;
  - `stall_en` is high and `lfsr[0]` is 1;
  - `read` and `write` are both high; this also sets `err`, and neither request is accepted;
  - `read` is high and `pending == MAX_PENDING` and no response retires this cycle.
- Read path:
  - The RAM is read in the acceptance cycle.
  - Data, or ERR_WORD if the word index is ≥ 2^DEPTH_LOG2, enters a READ_LATENCY-deep delay line with a valid bit.
  - An out-of-range read sets `err`.
- Write path:
  - The RAM word updates at the acceptance edge.
  - An out-of-range write is dropped and sets `err`.
  - Writes are accepted with reads outstanding.
- Ordering:
  - Responses return strictly in acceptance order.
  - A read accepted before a write to the same word returns the old data.
  - A read accepted at least one cycle after the write returns the new data.
- Pending count:
  - +1 on read acceptance, −1 on `readdatavalid`; simultaneous events leave it unchanged.
  - It never exceeds MAX_PENDING.
- Counters: reads and writes accepted are 32-bit and wrap at 2^32.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. It advances every cycle regardless of `stall_en`.
- Reset mid-operation:
  - Delay line, pending count, counters, `err` and LFSR all clear.
  - In-flight responses are discarded; none is emitted after reset.
  - RAM contents are preserved.

## Timing
- Read accepted at edge N → `readdatavalid` = 1 with data in cycle N+READ_LATENCY, for exactly one cycle per read.
- Back-to-back reads: throughput is min(1, MAX_PENDING/READ_LATENCY) per cycle. With the defaults, the pattern is 2 accepts followed by 1 wait.
- Reset values:
  - `readdatavalid` 0, `readdata` 0, `err` 0, `dbg_data` 0.
  - `waitrequest` is 1 while `reset` is high.
- `dbg_data` lags `dbg_sel` by 1 cycle.
- `err` rises the cycle after the offending request.

## Structure
- Package `notch_avalon_pkg`:
  - ERR_WORD, LFSR seed and taps;
  - debug select encodings;
  - SDRAM_WORD_SKIP constant shared with the filter master.
- Sub-module `resp_delay_line`: parameterised shift register of {valid, data[31:0]}, depth READ_LATENCY, synchronous clear.
- RAM is inferred in the top level, single port, read-during-write returns old data.

## Test plan
- Write 0x11223344 to address 0x10, then read 0x10 two cycles later → `readdatavalid` at acceptance+3 with 0x11223344; debug sel 0 and sel 1 each = 1.
- Hold `read` high for 6 cycles on addresses 0,4,8,…,20 → `waitrequest` pattern 0,0,1,0,0,1; 6 in-order responses; pending peaks at 2.
- Read 0x20 accepted, write 0x20 := 5 next cycle, read 0x20 again → responses are old value, then 5.
- Assert `read` and `write` together, then read address 4·2^DEPTH_LOG2 →
  - the simultaneous request is not accepted and `waitrequest` = 1 that cycle;
  - the out-of-range read returns 0xDEADBEEF;
  - `err` = 1 and stays set.
- Pulse `reset` one cycle after two reads are accepted → no `readdatavalid` afterward, pending = 0, and RAM contents intact on a subsequent read.
- `stall_en` = 1 with 1000 random reads/writes → `waitrequest` asserted 40–60% of cycles, zero lost or reordered responses, and counters match the scoreboard.
